// File: rtl/ex_mem_reg_if.sv
// Execute-to-memory stage bundle: control, execute results, registered stage outputs
// and the multi-cycle multiply-accumulate context returned to execute.
interface ex_mem_reg_if #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 2
);
  logic                    flush;
  logic                    stall_ex;
  logic                    stall_mem;

  logic [DATA_W-1:0]       ex_wdata;
  logic [REG_ADDR_W-1:0]   ex_wd;
  logic                    ex_wreg;
  logic                    ex_whilo;
  logic [DATA_W-1:0]       ex_hi;
  logic [DATA_W-1:0]       ex_lo;
  logic [2*DATA_W-1:0]     hilo_i;
  logic [CNT_W-1:0]        cnt_i;

  logic [DATA_W-1:0]       mem_wdata;
  logic [REG_ADDR_W-1:0]   mem_wd;
  logic                    mem_wreg;
  logic                    mem_whilo;
  logic [DATA_W-1:0]       mem_hi;
  logic [DATA_W-1:0]       mem_lo;
  logic [2*DATA_W-1:0]     hilo_o;
  logic [CNT_W-1:0]        cnt_o;

  // Pipeline/execute side driving the register.
  modport master (
    output flush, stall_ex, stall_mem,
    output ex_wdata, ex_wd, ex_wreg, ex_whilo, ex_hi, ex_lo, hilo_i, cnt_i,
    input  mem_wdata, mem_wd, mem_wreg, mem_whilo, mem_hi, mem_lo, hilo_o, cnt_o
  );

  // The pipeline register itself.
  modport slave (
    input  flush, stall_ex, stall_mem,
    input  ex_wdata, ex_wd, ex_wreg, ex_whilo, ex_hi, ex_lo, hilo_i, cnt_i,
    output mem_wdata, mem_wd, mem_wreg, mem_whilo, mem_hi, mem_lo, hilo_o, cnt_o
  );
endinterface

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register with flush, bubble and hold control, plus storage for the
// partial madd/msub product while the instruction is stalled in execute.
module ex_mem_reg #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 2
) (
  input logic         clk,
  input logic         rst,
  ex_mem_reg_if.slave bus
);

  logic [DATA_W-1:0]     mem_wdata_q, mem_wdata_d;
  logic [REG_ADDR_W-1:0] mem_wd_q,    mem_wd_d;
  logic                  mem_wreg_q,  mem_wreg_d;
  logic                  mem_whilo_q, mem_whilo_d;
  logic [DATA_W-1:0]     mem_hi_q,    mem_hi_d;
  logic [DATA_W-1:0]     mem_lo_q,    mem_lo_d;
  logic [2*DATA_W-1:0]   hilo_q,      hilo_d;
  logic [CNT_W-1:0]      cnt_q,       cnt_d;

  always_comb begin
    mem_wdata_d = mem_wdata_q;
    mem_wd_d    = mem_wd_q;
    mem_wreg_d  = mem_wreg_q;
    mem_whilo_d = mem_whilo_q;
    mem_hi_d    = mem_hi_q;
    mem_lo_d    = mem_lo_q;
    hilo_d      = hilo_q;
    cnt_d       = cnt_q;

    if (bus.flush) begin
      mem_wdata_d = '0;
      mem_wd_d    = '0;
      mem_wreg_d  = 1'b0;
      mem_whilo_d = 1'b0;
      mem_hi_d    = '0;
      mem_lo_d    = '0;
      hilo_d      = '0;
      cnt_d       = '0;
    end else begin
      unique case ({bus.stall_ex, bus.stall_mem})
        2'b10: begin
          // Bubble: memory stage sees a NOP, execute keeps its partial product here.
          mem_wdata_d = '0;
          mem_wd_d    = '0;
          mem_wreg_d  = 1'b0;
          mem_whilo_d = 1'b0;
          mem_hi_d    = '0;
          mem_lo_d    = '0;
          hilo_d      = bus.hilo_i;
          cnt_d       = bus.cnt_i;
        end
        2'b00: begin
          // Instruction advances, so the multi-cycle context is released.
          mem_wdata_d = bus.ex_wdata;
          mem_wd_d    = bus.ex_wd;
          mem_wreg_d  = bus.ex_wreg;
          mem_whilo_d = bus.ex_whilo;
          mem_hi_d    = bus.ex_hi;
          mem_lo_d    = bus.ex_lo;
          hilo_d      = '0;
          cnt_d       = '0;
        end
        // Both stalled holds; stall_mem alone never arrives and is held the same way.
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_wdata_q <= '0;
      mem_wd_q    <= '0;
      mem_wreg_q  <= 1'b0;
      mem_whilo_q <= 1'b0;
      mem_hi_q    <= '0;
      mem_lo_q    <= '0;
      hilo_q      <= '0;
      cnt_q       <= '0;
    end else begin
      mem_wdata_q <= mem_wdata_d;
      mem_wd_q    <= mem_wd_d;
      mem_wreg_q  <= mem_wreg_d;
      mem_whilo_q <= mem_whilo_d;
      mem_hi_q    <= mem_hi_d;
      mem_lo_q    <= mem_lo_d;
      hilo_q      <= hilo_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_wd    = mem_wd_q;
  assign bus.mem_wreg  = mem_wreg_q;
  assign bus.mem_whilo = mem_whilo_q;
  assign bus.mem_hi    = mem_hi_q;
  assign bus.mem_lo    = mem_lo_q;
  assign bus.hilo_o    = hilo_q;
  assign bus.cnt_o     = cnt_q;

endmodule

// File: tb/tb_ex_mem_reg.sv
// Directed bench for ex_mem_reg: reset, pass-through, madd bubble, hold, flush,
// illegal stall combination and reset in the middle of a multi-cycle operation.
module tb_ex_mem_reg;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;
  int   illegal_cnt;

  ex_mem_reg_if #(.DATA_W(32), .REG_ADDR_W(5), .CNT_W(2)) bus ();

  ex_mem_reg #(.DATA_W(32), .REG_ADDR_W(5), .CNT_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Flags the stall_mem-without-stall_ex combination the stall controller must never emit.
  always @(posedge clk) begin
    if (rst && !bus.stall_ex && bus.stall_mem) illegal_cnt <= illegal_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".wdata"}, 64'(bus.mem_wdata), 64'h0);
    chk({tag, ".wd"},    64'(bus.mem_wd),    64'h0);
    chk({tag, ".wreg"},  64'(bus.mem_wreg),  64'h0);
    chk({tag, ".whilo"}, 64'(bus.mem_whilo), 64'h0);
    chk({tag, ".hi"},    64'(bus.mem_hi),    64'h0);
    chk({tag, ".lo"},    64'(bus.mem_lo),    64'h0);
    chk({tag, ".hilo"},  bus.hilo_o,         64'h0);
    chk({tag, ".cnt"},   64'(bus.cnt_o),     64'h0);
  endtask

  logic [31:0] s_wdata [4] = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
  logic [4:0]  s_wd    [4] = '{5'd1, 5'd2, 5'd3, 5'd31};
  logic [31:0] s_hi    [4] = '{32'hA000_0001, 32'hA000_0002, 32'hA000_0003, 32'hA000_0004};
  logic [31:0] s_lo    [4] = '{32'hB000_0001, 32'hB000_0002, 32'hB000_0003, 32'hB000_0004};

  initial begin
    n_cmp       = 0;
    n_fail      = 0;
    illegal_cnt = 0;

    // Reset with every execute input at all-ones.
    rst           = 1'b0;
    bus.flush     = 1'b0;
    bus.stall_ex  = 1'b0;
    bus.stall_mem = 1'b0;
    bus.ex_wdata  = '1;
    bus.ex_wd     = '1;
    bus.ex_wreg   = 1'b1;
    bus.ex_whilo  = 1'b1;
    bus.ex_hi     = '1;
    bus.ex_lo     = '1;
    bus.hilo_i    = '1;
    bus.cnt_i     = '1;
    tick();
    chk_all_zero("rst0");
    tick();
    chk_all_zero("rst1");

    // First instruction after reset release.
    rst          = 1'b1;
    bus.ex_wdata = 32'h1234_5678;
    bus.ex_wd    = 5'd7;
    bus.ex_wreg  = 1'b1;
    bus.ex_whilo = 1'b0;
    tick();
    chk("rel.wdata", 64'(bus.mem_wdata), 64'h1234_5678);
    chk("rel.wd",    64'(bus.mem_wd),    64'd7);
    chk("rel.wreg",  64'(bus.mem_wreg),  64'd1);
    chk("rel.whilo", 64'(bus.mem_whilo), 64'd0);
    chk("rel.hi",    64'(bus.mem_hi),    64'hFFFF_FFFF);
    chk("rel.hilo",  bus.hilo_o,         64'h0);
    chk("rel.cnt",   64'(bus.cnt_o),     64'h0);

    // Back-to-back pass-through stream.
    for (int i = 0; i < 4; i++) begin
      bus.ex_wdata = s_wdata[i];
      bus.ex_wd    = s_wd[i];
      bus.ex_wreg  = i[0];
      bus.ex_whilo = 1'b1;
      bus.ex_hi    = s_hi[i];
      bus.ex_lo    = s_lo[i];
      bus.hilo_i   = 64'h5555_0000_0000_0000 | 64'(i);
      bus.cnt_i    = 2'(i);
      tick();
      chk($sformatf("strm%0d.wdata", i), 64'(bus.mem_wdata), 64'(s_wdata[i]));
      chk($sformatf("strm%0d.wd", i),    64'(bus.mem_wd),    64'(s_wd[i]));
      chk($sformatf("strm%0d.wreg", i),  64'(bus.mem_wreg),  64'(i % 2));
      chk($sformatf("strm%0d.whilo", i), 64'(bus.mem_whilo), 64'd1);
      chk($sformatf("strm%0d.hi", i),    64'(bus.mem_hi),    64'(s_hi[i]));
      chk($sformatf("strm%0d.lo", i),    64'(bus.mem_lo),    64'(s_lo[i]));
      chk($sformatf("strm%0d.hilo", i),  bus.hilo_o,         64'h0);
      chk($sformatf("strm%0d.cnt", i),   64'(bus.cnt_o),     64'h0);
    end

    // madd cycle 0: bubble downstream, partial product captured.
    bus.stall_ex = 1'b1;
    bus.ex_wreg  = 1'b1;
    bus.ex_whilo = 1'b1;
    bus.hilo_i   = 64'h0000_0001_FFFF_FFFE;
    bus.cnt_i    = 2'd1;
    tick();
    chk("madd0.wreg",  64'(bus.mem_wreg),  64'd0);
    chk("madd0.whilo", 64'(bus.mem_whilo), 64'd0);
    chk("madd0.wdata", 64'(bus.mem_wdata), 64'h0);
    chk("madd0.hilo",  bus.hilo_o,         64'h0000_0001_FFFF_FFFE);
    chk("madd0.cnt",   64'(bus.cnt_o),     64'd1);

    // madd cycle 1: final HI/LO written, context released.
    bus.stall_ex = 1'b0;
    bus.ex_wreg  = 1'b0;
    bus.ex_whilo = 1'b1;
    bus.ex_hi    = 32'h2;
    bus.ex_lo    = 32'h5;
    bus.hilo_i   = 64'h0000_0002_0000_0005;
    bus.cnt_i    = 2'd2;
    tick();
    chk("madd1.hi",    64'(bus.mem_hi),    64'h2);
    chk("madd1.lo",    64'(bus.mem_lo),    64'h5);
    chk("madd1.whilo", 64'(bus.mem_whilo), 64'd1);
    chk("madd1.hilo",  bus.hilo_o,         64'h0);
    chk("madd1.cnt",   64'(bus.cnt_o),     64'd0);

    // Hold: both stages stalled for three cycles while execute inputs change.
    bus.ex_wdata = 32'hCAFE_F00D;
    bus.ex_wd    = 5'd9;
    bus.ex_wreg  = 1'b1;
    tick();
    chk("load.wdata", 64'(bus.mem_wdata), 64'hCAFE_F00D);
    bus.stall_ex  = 1'b1;
    bus.stall_mem = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.ex_wdata = 32'h0000_0031 + 32'(i);
      bus.ex_wd    = 5'(20 + i);
      bus.hilo_i   = 64'h7777_0000_0000_0000 | 64'(i);
      bus.cnt_i    = 2'd3;
      tick();
      chk($sformatf("hold%0d.wdata", i), 64'(bus.mem_wdata), 64'hCAFE_F00D);
      chk($sformatf("hold%0d.wd", i),    64'(bus.mem_wd),    64'd9);
      chk($sformatf("hold%0d.hilo", i),  bus.hilo_o,         64'h0);
      chk($sformatf("hold%0d.cnt", i),   64'(bus.cnt_o),     64'd0);
    end
    bus.stall_ex  = 1'b0;
    bus.stall_mem = 1'b0;
    bus.ex_wdata  = 32'h0BAD_C0DE;
    bus.ex_wd     = 5'd12;
    tick();
    chk("hrel.wdata", 64'(bus.mem_wdata), 64'h0BAD_C0DE);
    chk("hrel.wd",    64'(bus.mem_wd),    64'd12);

    // Flush during a full stall with live multi-cycle context.
    bus.stall_ex = 1'b1;
    bus.hilo_i   = 64'hDEAD_BEEF_0000_0001;
    bus.cnt_i    = 2'd1;
    tick();
    bus.stall_mem = 1'b1;
    bus.hilo_i    = 64'h1;
    bus.cnt_i     = 2'd2;
    tick();
    chk("fpre.hilo", bus.hilo_o,     64'hDEAD_BEEF_0000_0001);
    chk("fpre.cnt",  64'(bus.cnt_o), 64'd1);
    bus.flush = 1'b1;
    tick();
    chk_all_zero("flush_stall");

    // Flush beats a normal advance.
    bus.stall_ex  = 1'b0;
    bus.stall_mem = 1'b0;
    bus.ex_wdata  = 32'h8765_4321;
    bus.ex_wreg   = 1'b1;
    tick();
    chk_all_zero("flush_norm");
    bus.flush = 1'b0;

    // Illegal stall_mem-only combination behaves as hold and is flagged.
    bus.ex_wdata = 32'h0000_A5A5;
    tick();
    chk("ill.pre", 64'(bus.mem_wdata), 64'h0000_A5A5);
    bus.stall_mem = 1'b1;
    bus.ex_wdata  = 32'h0000_5A5A;
    tick();
    chk("ill.wdata", 64'(bus.mem_wdata), 64'h0000_A5A5);
    chk("ill.flag",  64'(illegal_cnt),   64'd1);
    bus.stall_mem = 1'b0;

    // Reset in the middle of a madd.
    bus.stall_ex = 1'b1;
    bus.hilo_i   = 64'h1234_5678_9ABC_DEF0;
    bus.cnt_i    = 2'd2;
    tick();
    chk("rmid.hilo", bus.hilo_o,     64'h1234_5678_9ABC_DEF0);
    chk("rmid.cnt",  64'(bus.cnt_o), 64'd2);
    rst = 1'b0;
    #2;
    chk("rmid.sync", bus.hilo_o, 64'h1234_5678_9ABC_DEF0);
    tick();
    chk_all_zero("rmid");
    rst          = 1'b1;
    bus.stall_ex = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
